// File: rtl/pc_branch_unit.sv
// pc_branch_unit: RV32I program counter with conditional branch resolution, flush pulse, misalignment halt and branch counters
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic [2:0]       funct3,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_ltu,
  input  logic [31:0]      imm_b,
  output logic [31:0]      pc,
  output logic [31:0]      pc_next,
  output logic             branch_taken,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);
  localparam logic RUN  = 1'b0;
  localparam logic HALT = 1'b1;
  logic state;
  logic cond;
  logic [31:0] target;
  logic [31:0] seq;
  logic misaligned;
  always_comb begin
    cond = (funct3 == 3'b000) ? alu_zero :
           (funct3 == 3'b001) ? !alu_zero :
           (funct3 == 3'b100) ? alu_lt :
           (funct3 == 3'b101) ? !alu_lt :
           (funct3 == 3'b110) ? alu_ltu :
           (funct3 == 3'b111) ? !alu_ltu : 1'b0;
    target = pc + imm_b;
    seq = pc + 32'd4;
    branch_taken = branch & cond & (state == RUN);
    pc_next = branch_taken ? target : seq;
    misaligned = branch_taken & (target[1:0] != 2'b00);
  end
  assign halted = (state == HALT);
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      state <= RUN;
      flush <= 1'b0;
      branch_count <= '0;
      taken_count <= '0;
    end else if (state == RUN && !stall) begin
      if (misaligned) begin
        state <= HALT;
        flush <= 1'b0;
      end else begin
        pc <= pc_next;
        flush <= branch_taken;
        if (branch && branch_count != {CNT_W{1'b1}}) branch_count <= branch_count + 1'b1;
        if (branch_taken && taken_count != {CNT_W{1'b1}}) taken_count <= taken_count + 1'b1;
      end
    end else begin
      flush <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: scoreboard bench for pc_branch_unit with a default and a 4-bit-counter instance
module tb_pc_branch_unit;
  logic clk = 1'b0;
  logic reset, stall, branch, alu_zero, alu_lt, alu_ltu;
  logic [2:0] funct3;
  logic [31:0] imm_b;
  logic [31:0] pc, pc_next, pc4, pc_next4;
  logic branch_taken, flush, halted, branch_taken4, flush4, halted4;
  logic [15:0] branch_count, taken_count;
  logic [3:0] branch_count4, taken_count4;
  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic flush;
    logic halted;
    logic [15:0] bc;
    logic [15:0] tc;
    logic [3:0] bc4;
    logic [3:0] tc4;
  } exp_t;
  exp_t q[$];

  logic [31:0] m_pc;
  logic m_halt, m_flush;
  logic [15:0] m_bc, m_tc;
  logic [3:0] m_bc4, m_tc4;

  pc_branch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .funct3(funct3),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .imm_b(imm_b),
    .pc(pc), .pc_next(pc_next), .branch_taken(branch_taken), .flush(flush),
    .halted(halted), .branch_count(branch_count), .taken_count(taken_count)
  );

  pc_branch_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .funct3(funct3),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .imm_b(imm_b),
    .pc(pc4), .pc_next(pc_next4), .branch_taken(branch_taken4), .flush(flush4),
    .halted(halted4), .branch_count(branch_count4), .taken_count(taken_count4)
  );

  always #5 clk = ~clk;

  function automatic logic cond_of(input logic [2:0] f, input logic z, input logic lt, input logic ltu);
    case (f)
      3'b000: return z;
      3'b001: return !z;
      3'b100: return lt;
      3'b101: return !lt;
      3'b110: return ltu;
      3'b111: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic cycle(input logic rst, input logic st, input logic br, input logic [2:0] f3,
                       input logic z, input logic lt, input logic ltu, input logic [31:0] imm);
    logic tk;
    logic [31:0] tgt, nxt;
    exp_t e, got;
    reset = rst; stall = st; branch = br; funct3 = f3;
    alu_zero = z; alu_lt = lt; alu_ltu = ltu; imm_b = imm;
    #1;
    tk = br & cond_of(f3, z, lt, ltu) & !m_halt;
    tgt = m_pc + imm;
    nxt = tk ? tgt : m_pc + 32'd4;
    vectors += 2;
    if (branch_taken !== tk) begin
      miscompares++;
      $display("FAIL branch_taken: got %b expected %b (pc %h f3 %b)", branch_taken, tk, m_pc, f3);
    end
    if (pc_next !== nxt) begin
      miscompares++;
      $display("FAIL pc_next: got %h expected %h", pc_next, nxt);
    end
    if (rst) begin
      m_pc = 32'h0; m_halt = 0; m_flush = 0; m_bc = 0; m_tc = 0; m_bc4 = 0; m_tc4 = 0;
    end else if (m_halt || st) begin
      m_flush = 0;
    end else if (tk && tgt[1:0] != 2'b00) begin
      m_halt = 1; m_flush = 0;
    end else begin
      m_pc = nxt;
      m_flush = tk;
      if (br) begin
        m_bc = (m_bc == 16'hFFFF) ? m_bc : m_bc + 16'd1;
        m_bc4 = (m_bc4 == 4'hF) ? m_bc4 : m_bc4 + 4'd1;
      end
      if (tk) begin
        m_tc = (m_tc == 16'hFFFF) ? m_tc : m_tc + 16'd1;
        m_tc4 = (m_tc4 == 4'hF) ? m_tc4 : m_tc4 + 4'd1;
      end
    end
    q.push_back('{m_pc, m_flush, m_halt, m_bc, m_tc, m_bc4, m_tc4});
    @(posedge clk);
    #1;
    e = q.pop_front();
    got = '{pc, flush, halted, branch_count, taken_count, branch_count4, taken_count4};
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL state: got pc=%h fl=%b h=%b bc=%0d tc=%0d bc4=%0d tc4=%0d expected pc=%h fl=%b h=%b bc=%0d tc=%0d bc4=%0d tc4=%0d",
               got.pc, got.flush, got.halted, got.bc, got.tc, got.bc4, got.tc4,
               e.pc, e.flush, e.halted, e.bc, e.tc, e.bc4, e.tc4);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 3'b000, 0, 0, 0, 32'h0);
  endtask

  task automatic test_reset;
    cycle(1, 0, 1, 3'b000, 1, 0, 0, 32'h8);
    cycle(1, 0, 1, 3'b000, 1, 0, 0, 32'h8);
    vectors++;
    if (pc !== 32'h0 || flush !== 1'b0 || halted !== 1'b0 || branch_count !== 16'h0 || taken_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset: got pc=%h fl=%b h=%b bc=%0d tc=%0d required all zero", pc, flush, halted, branch_count, taken_count);
    end
    idle(3);
    vectors++;
    if (pc !== 32'hC) begin
      miscompares++;
      $display("FAIL reset_step: got %h expected 0000000c", pc);
    end
  endtask

  task automatic test_beq;
    idle(1);
    cycle(0, 0, 1, 3'b000, 1, 0, 0, 32'hFFFF_FFF8);
    vectors++;
    if (pc !== 32'h8 || flush !== 1'b1 || taken_count !== 16'd1 || branch_count !== 16'd1) begin
      miscompares++;
      $display("FAIL beq: got pc=%h fl=%b tc=%0d bc=%0d expected pc=8 fl=1 tc=1 bc=1", pc, flush, taken_count, branch_count);
    end
    idle(1);
    vectors++;
    if (flush !== 1'b0) begin
      miscompares++;
      $display("FAIL beq_flush_width: got %b expected 0", flush);
    end
  endtask

  task automatic test_not_taken;
    cycle(1, 0, 0, 3'b000, 0, 0, 0, 32'h0);
    idle(8);
    cycle(0, 0, 1, 3'b001, 1, 0, 0, 32'h40);
    cycle(0, 0, 1, 3'b010, 1, 1, 1, 32'h40);
    vectors++;
    if (pc !== 32'h28 || branch_count !== 16'd2 || taken_count !== 16'd0) begin
      miscompares++;
      $display("FAIL not_taken: got pc=%h bc=%0d tc=%0d expected pc=28 bc=2 tc=0", pc, branch_count, taken_count);
    end
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 8; c++)
        cycle(0, 0, 1, 3'(f), c[0], c[1], c[2], 32'h10);
  endtask

  task automatic test_stall;
    logic [31:0] p0;
    p0 = m_pc;
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 3'b110, 0, 0, 1, 32'h40);
    cycle(0, 0, 1, 3'b110, 0, 0, 1, 32'h40);
    vectors++;
    if (pc !== p0 + 32'h40 || flush !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: got pc=%h fl=%b expected pc=%h fl=1", pc, flush, p0 + 32'h40);
    end
    idle(1);
  endtask

  task automatic test_back_to_back;
    cycle(0, 0, 1, 3'b101, 0, 0, 0, 32'h8);
    cycle(0, 0, 1, 3'b111, 0, 0, 0, 32'h8);
    vectors++;
    if (flush !== 1'b1) begin
      miscompares++;
      $display("FAIL back_to_back: got flush %b expected 1", flush);
    end
    idle(1);
  endtask

  task automatic test_misaligned;
    cycle(0, 0, 1, 3'b000, 1, 0, 0, 32'h100 - m_pc);
    cycle(0, 0, 1, 3'b000, 1, 0, 0, 32'h6);
    vectors++;
    if (halted !== 1'b1 || pc !== 32'h100 || flush !== 1'b0) begin
      miscompares++;
      $display("FAIL misaligned: got h=%b pc=%h fl=%b expected h=1 pc=100 fl=0", halted, pc, flush);
    end
    for (int i = 0; i < 6; i++) cycle(0, i[0], 1, 3'b001, 0, 0, 0, 32'h8);
    cycle(1, 0, 0, 3'b000, 0, 0, 0, 32'h0);
    vectors++;
    if (halted !== 1'b0 || pc !== 32'h0) begin
      miscompares++;
      $display("FAIL halt_reset: got h=%b pc=%h expected h=0 pc=0", halted, pc);
    end
  endtask

  task automatic test_wrap_saturation;
    cycle(0, 0, 1, 3'b000, 1, 0, 0, 32'hFFFF_FFFC);
    idle(1);
    vectors++;
    if (pc !== 32'h0) begin
      miscompares++;
      $display("FAIL pc_wrap: got %h expected 00000000", pc);
    end
    cycle(1, 0, 0, 3'b000, 0, 0, 0, 32'h0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 3'b000, 1, 0, 0, 32'h4);
    vectors++;
    if (branch_count4 !== 4'hF || taken_count4 !== 4'hF || taken_count !== 16'd20) begin
      miscompares++;
      $display("FAIL saturation: got bc4=%h tc4=%h tc=%0d expected f f 20", branch_count4, taken_count4, taken_count);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] imm;
      imm = {$urandom_range(0, 255) - 128, 2'b00};
      if ($urandom_range(0, 40) == 0) imm[1] = 1'b1;
      cycle($urandom_range(0, 30) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom), imm);
    end
  endtask

  initial begin
    m_pc = 0; m_halt = 0; m_flush = 0; m_bc = 0; m_tc = 0; m_bc4 = 0; m_tc4 = 0;
    reset = 1; stall = 0; branch = 0; funct3 = 0; alu_zero = 0; alu_lt = 0; alu_ltu = 0; imm_b = 0;
    @(posedge clk);
    #1;
    test_reset;
    test_beq;
    test_not_taken;
    test_stall;
    test_back_to_back;
    test_misaligned;
    test_wrap_saturation;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
